// File: rtl/md5_arb_pkg.sv
// rtl/md5_arb_pkg.sv - shared types, widths and helpers for the md5 core arbiter
package md5_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int MSG_W    = 128;
  localparam int DIGEST_W = 128;
  localparam int WIDTH_W  = 8;

  // Sized for the largest supported requester count (8); callers truncate.
  function automatic logic [7:0] onehot(input logic [2:0] id);
    return 8'b1 << id;
  endfunction

endpackage

// File: rtl/md5_core_arbiter_rr_arbiter.sv
// rtl/md5_core_arbiter_rr_arbiter.sv - round-robin pick starting after last_grant
module rr_arbiter
  import md5_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  assign any = |req;

  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    grant_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        grant_id = w_idx;
      end
    end
    grant_onehot = (enable && w_found) ? NUM_REQ'(onehot(3'(grant_id))) : '0;
  end

endmodule

// File: rtl/md5_core_arbiter.sv
// rtl/md5_core_arbiter.sv - shares one pancham MD5 core among NUM_REQ generators
// Optional digest/target matcher enabled by MD5_ARB_MATCH_EN.
module md5_core_arbiter
  import md5_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef MD5_ARB_MATCH_EN
  input  logic [DIGEST_W-1:0]        target,
  output logic                       match_found,
  output logic [ID_W-1:0]            match_id,
  output logic [MSG_W-1:0]           match_msg,
`endif
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MSG_W-1:0]   req_msg,
  input  logic [NUM_REQ*WIDTH_W-1:0] req_width,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DIGEST_W-1:0]        rsp_digest,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       busy,
  output logic [31:0]                issued_cnt,
  output logic [MSG_W-1:0]           core_msg_in,
  output logic [WIDTH_W-1:0]         core_msg_in_width,
  output logic                       core_msg_in_valid,
  input  logic [DIGEST_W-1:0]        core_msg_output,
  input  logic                       core_msg_out_valid,
  input  logic                       core_ready
);

  state_t               r_state, w_state_nxt;
  logic [ID_W-1:0]      r_last_grant, r_owner, r_rsp_id, w_grant_id;
  logic [NUM_REQ-1:0]   w_grant_oh, r_rsp_valid;
  logic                 w_any, w_arb_en, w_xfer, w_rsp;
  logic [MSG_W-1:0]     r_msg;
  logic [WIDTH_W-1:0]   r_width;
  logic [DIGEST_W-1:0]  r_rsp_digest;
  logic [31:0]          r_issued_cnt;

  assign w_arb_en = (r_state == IDLE) && core_ready;
  assign w_xfer   = w_arb_en && w_any;
  // Digests arriving outside WAIT belong to nobody and are dropped.
  assign w_rsp    = (r_state == WAIT) && core_msg_out_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req          (req_valid),
    .last_grant   (r_last_grant),
    .enable       (w_arb_en),
    .grant_onehot (w_grant_oh),
    .grant_id     (w_grant_id),
    .any          (w_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (core_msg_out_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_msg        <= '0;
      r_width      <= '0;
      r_issued_cnt <= '0;
      r_rsp_valid  <= '0;
      r_rsp_digest <= '0;
      r_rsp_id     <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_xfer) begin
        r_msg        <= req_msg[w_grant_id*MSG_W +: MSG_W];
        r_width      <= req_width[w_grant_id*WIDTH_W +: WIDTH_W];
        r_owner      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == ISSUE) r_issued_cnt <= r_issued_cnt + 32'd1;
      if (w_rsp) begin
        r_rsp_digest <= core_msg_output;
        r_rsp_id     <= r_owner;
        r_rsp_valid  <= NUM_REQ'(onehot(3'(r_owner)));
      end
    end
  end

`ifdef MD5_ARB_MATCH_EN
  logic              r_match_found;
  logic [ID_W-1:0]   r_match_id;
  logic [MSG_W-1:0]  r_match_msg;

  // First hit wins; r_msg still holds the owner's message during WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match_found <= 1'b0;
      r_match_id    <= '0;
      r_match_msg   <= '0;
    end else if (w_rsp && !r_match_found && (core_msg_output == target)) begin
      r_match_found <= 1'b1;
      r_match_id    <= r_owner;
      r_match_msg   <= r_msg;
    end
  end

  assign match_found = r_match_found;
  assign match_id    = r_match_id;
  assign match_msg   = r_match_msg;
`endif

  assign req_ready         = w_grant_oh;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_digest        = r_rsp_digest;
  assign rsp_id            = r_rsp_id;
  assign busy              = (r_state != IDLE);
  assign issued_cnt        = r_issued_cnt;
  assign core_msg_in       = r_msg;
  assign core_msg_in_width = r_width;
  assign core_msg_in_valid = (r_state == ISSUE);

endmodule

// File: tb/tb_md5_core_arbiter.sv
// tb/tb_md5_core_arbiter.sv - directed bench for md5_core_arbiter with a stub pancham core
module tb_md5_core_arbiter;

  localparam logic [127:0] ABC_MSG = {24'h616263, 104'h0};
  localparam logic [127:0] ABC_DIG = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam int           LAT     = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]   req_valid;
  wire  [3:0]   req_ready;
  logic [511:0] req_msg;
  logic [31:0]  req_width;
  wire  [3:0]   rsp_valid;
  wire  [127:0] rsp_digest;
  wire  [1:0]   rsp_id;
  wire          busy;
  wire  [31:0]  issued_cnt;
  wire  [127:0] core_msg_in;
  wire  [7:0]   core_msg_in_width;
  wire          core_msg_in_valid;
  wire  [127:0] core_msg_output;
  wire          core_msg_out_valid;
  wire          core_ready;
`ifdef MD5_ARB_MATCH_EN
  logic [127:0] target;
  wire          match_found;
  wire  [1:0]   match_id;
  wire  [127:0] match_msg;
`endif

  // Stub core: real digest for "abc", an arbitrary mixing function otherwise.
  function automatic logic [127:0] tb_dig(input logic [127:0] m, input logic [7:0] w);
    if (m == ABC_MSG && w == 8'd24) return ABC_DIG;
    return {m[63:0], m[127:64]} ^ {120'h0, w};
  endfunction

  logic         m_ready, m_ov, man_ov, hold_ready;
  logic [127:0] m_dig, man_dig;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1; m_ov <= 1'b0; m_cnt <= 0; m_dig <= '0;
    end else begin
      m_ov <= 1'b0;
      if (core_msg_in_valid && m_ready) begin
        m_cnt <= LAT; m_ready <= 1'b0; m_dig <= tb_dig(core_msg_in, core_msg_in_width);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin m_ov <= 1'b1; m_ready <= 1'b1; end
      end
    end
  end

  assign core_ready         = m_ready & ~hold_ready;
  assign core_msg_out_valid = m_ov | man_ov;
  assign core_msg_output    = man_ov ? man_dig : m_dig;

  md5_core_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(rst_n),
`ifdef MD5_ARB_MATCH_EN
    .target(target), .match_found(match_found), .match_id(match_id), .match_msg(match_msg),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg), .req_width(req_width),
    .rsp_valid(rsp_valid), .rsp_digest(rsp_digest), .rsp_id(rsp_id), .busy(busy),
    .issued_cnt(issued_cnt), .core_msg_in(core_msg_in), .core_msg_in_width(core_msg_in_width),
    .core_msg_in_valid(core_msg_in_valid), .core_msg_output(core_msg_output),
    .core_msg_out_valid(core_msg_out_valid), .core_ready(core_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [127:0] m, input logic [7:0] w);
    req_msg[i*128 +: 128] = m;
    req_width[i*8 +: 8]   = w;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (core_msg_in_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check(tag, 128'(core_msg_in_valid), 128'd1);
  endtask

  // Leaves the bench on the negedge where out_valid is seen; the response is one cycle later.
  task automatic wait_ov(input string tag);
    int n = 0;
    while (core_msg_out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check(tag, 128'(core_msg_out_valid), 128'd1);
    check({tag, "_rsp_early"}, 128'(rsp_valid), 128'd0);
  endtask

  logic [127:0] tmsg [4];
  logic [7:0]   twid [4];
  int           bad;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_msg = '0; req_width = '0;
    man_ov = 1'b0; man_dig = '0; hold_ready = 1'b0;
`ifdef MD5_ARB_MATCH_EN
    target = ABC_DIG;
`endif
    for (int i = 0; i < 4; i++) begin
      tmsg[i] = 128'hC0DE_0000_1234_5678_0000_0000_0000_0000 + 128'(i);
      twid[i] = 8'(8 * (i + 1));
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_cnt", 128'(issued_cnt), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_digest", rsp_digest, 128'd0);
    check("rst_in_valid", 128'(core_msg_in_valid), 128'd0);

    // single request "abc" from requester 0
    set_req(0, ABC_MSG, 8'd24);
    req_valid = 4'b0001;
    #1 check("t1_ready", 128'(req_ready), 128'h1);
    @(negedge clk);
    check("t1_in_valid", 128'(core_msg_in_valid), 128'd1);
    check("t1_msg", core_msg_in, ABC_MSG);
    check("t1_width", 128'(core_msg_in_width), 128'd24);
    check("t1_cnt_before", 128'(issued_cnt), 128'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    check("t1_in_valid_pulse", 128'(core_msg_in_valid), 128'd0);
    check("t1_cnt", 128'(issued_cnt), 128'd1);
    check("t1_busy", 128'(busy), 128'd1);
    wait_ov("t1_ov");
    @(negedge clk);
    check("t1_rsp_valid", 128'(rsp_valid), 128'h1);
    check("t1_digest", rsp_digest, ABC_DIG);
    check("t1_id", 128'(rsp_id), 128'd0);
    @(negedge clk);
    check("t1_rsp_pulse", 128'(rsp_valid), 128'd0);
    check("t1_digest_hold", rsp_digest, ABC_DIG);

    // round robin with all four requesters holding valid
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, tmsg[i], twid[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_issue($sformatf("rr%0d_issue", k));
      check($sformatf("rr%0d_msg", k), core_msg_in, tmsg[k % 4]);
      wait_ov($sformatf("rr%0d_ov", k));
      @(negedge clk);
      check($sformatf("rr%0d_rsp_valid", k), 128'(rsp_valid), 128'(4'b1 << (k % 4)));
      check($sformatf("rr%0d_id", k), 128'(rsp_id), 128'(k % 4));
      check($sformatf("rr%0d_digest", k), rsp_digest, tb_dig(tmsg[k % 4], twid[k % 4]));
      if (k == 4) begin
        req_valid = 4'b0000;
        check("rr_cnt", 128'(issued_cnt), 128'd5);
      end else begin
        check($sformatf("rr%0d_next_ready", k), 128'(req_ready), 128'(4'b1 << ((k + 1) % 4)));
      end
    end

    // core not ready for 20 cycles with requester 1 pending
    @(negedge clk);
    hold_ready = 1'b1;
    req_valid  = 4'b0010;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1 if (req_ready !== 4'b0000 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("hold_no_grant", 128'(bad), 128'd0);
    hold_ready = 1'b0;
    #1 check("hold_release_ready", 128'(req_ready), 128'h2);
    @(negedge clk);
    check("hold_in_valid", 128'(core_msg_in_valid), 128'd1);
    check("hold_msg", core_msg_in, tmsg[1]);
    req_valid = 4'b0000;
    wait_ov("hold_ov");
    @(negedge clk);
    check("hold_rsp_valid", 128'(rsp_valid), 128'h2);

    // stray out_valid while idle
    @(negedge clk);
    man_dig = 128'hDEAD_BEEF; man_ov = 1'b1;
    @(negedge clk);
    man_ov = 1'b0;
    check("idle_ov_rsp", 128'(rsp_valid), 128'd0);
    check("idle_ov_busy", 128'(busy), 128'd0);
    check("idle_ov_digest", rsp_digest, tb_dig(tmsg[1], twid[1]));
    check("idle_ov_cnt", 128'(issued_cnt), 128'd6);

    // reset during WAIT discards the in-flight digest
    set_req(2, tmsg[2], twid[2]);
    req_valid = 4'b0100;
    wait_issue("mid_issue");
    req_valid = 4'b0000;
    repeat (10) @(negedge clk);
    check("mid_busy", 128'(busy), 128'd1);
    check("mid_cnt", 128'(issued_cnt), 128'd7);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_cnt", 128'(issued_cnt), 128'd0);
    man_dig = tb_dig(tmsg[2], twid[2]); man_ov = 1'b1;
    @(negedge clk);
    man_ov = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("mid_no_rsp", 128'(bad), 128'd0);

`ifdef MD5_ARB_MATCH_EN
    check("match_init", 128'(match_found), 128'd0);
    set_req(2, ABC_MSG, 8'd24);
    req_valid = 4'b0100;
    wait_issue("match_issue");
    req_valid = 4'b0000;
    wait_ov("match_ov");
    @(negedge clk);
    check("match_found", 128'(match_found), 128'd1);
    check("match_id", 128'(match_id), 128'd2);
    check("match_msg", match_msg, ABC_MSG);
    req_valid = 4'b0001;
    wait_issue("nomatch_issue");
    req_valid = 4'b0000;
    wait_ov("nomatch_ov");
    @(negedge clk);
    check("nomatch_rsp", 128'(rsp_valid), 128'h1);
    check("nomatch_found", 128'(match_found), 128'd1);
    check("nomatch_id", 128'(match_id), 128'd2);
    check("nomatch_msg", match_msg, ABC_MSG);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md5_core_arbiter.md
Name: md5_core_arbiter

Overview:
- Shares one pancham MD5 core between NUM_REQ candidate generators, so several charset walkers can feed a single hash engine.
- Grants round-robin and issues one message at a time: the core is not pipelined, so only one message is in flight.
- Routes each digest back to the requester that issued it, tagged with that requester's id.
- Sits between the generator front-ends and pancham; the usart/result path is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  NUM_REQ  per-requester message valid.
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- req_msg  in  NUM_REQ*128  flattened messages; requester i uses bits [i*128 +: 128].
- req_width  in  NUM_REQ*8  flattened message widths in bits; requester i uses [i*8 +: 8].
- rsp_valid  out  NUM_REQ  one-cycle pulse to the owning requester.
- rsp_digest  out  128  digest; broadcast to all requesters, qualified by rsp_valid.
- rsp_id  out  ID_W  owner id of the current rsp_digest.
- busy  out  1  high in ISSUE or WAIT.
- issued_cnt  out  32  count of messages issued to the core; wraps.
- core_msg_in  out  128  to pancham msg_in.
- core_msg_in_width  out  8  to pancham msg_in_width.
- core_msg_in_valid  out  1  to pancham msg_in_valid.
- core_msg_output  in  128  from pancham msg_output.
- core_msg_out_valid  in  1  from pancham msg_out_valid.
- core_ready  in  1  from pancham ready.

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = NUM_REQ-1 (so requester 0 has first priority), owner = 0.
- IDLE:
  - req_ready = onehot(g) only when core_ready = 1 and any req_valid is set; otherwise req_ready = 0.
  - g is the first set req_valid searching from last_grant+1 upward, wrapping at NUM_REQ.
  - req_ready is combinational from req_valid, core_ready, state and last_grant.
  - On transfer (cycle T): latch msg and width into core_msg_in and core_msg_in_width; owner <= g; last_grant <= g; go to ISSUE.
- ISSUE:
  - core_msg_in_valid = 1 for exactly one cycle (T+1).
  - issued_cnt increments by 1.
  - Go to WAIT.
- WAIT:
  - req_ready = 0.
  - On core_msg_out_valid = 1: rsp_digest <= core_msg_output, rsp_id <= owner, rsp_valid <= onehot(owner) for one cycle, go to IDLE.
  - Response latency is one cycle after core_msg_out_valid.
- Holding values:
  - core_msg_in and core_msg_in_width hold their values after issue.
  - rsp_digest and rsp_id hold until the next response.
- Boundary cases:
  - core_msg_out_valid in IDLE or ISSUE: ignored, no rsp_valid.
  - core_ready low in IDLE: no grant; pending requests are held, and the requester keeps req_valid asserted.
  - Requester drops req_valid before it is granted: no penalty, no grant.
  - Only one requester active: it is granted back-to-back every round.
  - A new grant can occur the cycle after rsp_valid, provided core_ready = 1.
  - Reset asserted mid-WAIT: state returns to IDLE, the in-flight digest is discarded, and no rsp_valid is produced.

Optional Feature:
- Macro: MD5_ARB_MATCH_EN.
- With the macro:
  - Adds input target (128 bits) and outputs match_found (1), match_id (ID_W), match_msg (128).
  - On a response whose digest equals target: match_found sets and is sticky until reset; match_id and match_msg latch that owner and its message.
  - Only the first match is captured.
  - Arbitration continues after a match.
- Without the macro: these ports and the comparator are absent.

Decomposition:
- Package md5_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - constants MSG_W = 128, DIGEST_W = 128, WIDTH_W = 8;
  - function onehot(id).
- Sub-module rr_arbiter(NUM_REQ): inputs req vector, last_grant and enable; outputs grant_onehot, grant_id, any.

Test Plan:
- Single request, core model latency 64: req0 sends "abc" (width 24) → core_msg_in_valid at T+1; rsp_valid[0] one cycle after out_valid; rsp_digest = 900150983cd24fb0d6963f7d28e17f72; rsp_id = 0.
- All 4 requesters hold req_valid → grant order 0,1,2,3,0; issued_cnt = 5; each rsp_valid reaches its owner only.
- core_ready = 0 for 20 cycles with req1 pending → req_ready stays 0; grant occurs the first cycle core_ready = 1.
- core_msg_out_valid pulsed in IDLE → no rsp_valid, state unchanged.
- Reset asserted mid-WAIT, then out_valid → no rsp_valid; busy = 0; issued_cnt = 0.
- MD5_ARB_MATCH_EN, target = 900150983cd24fb0d6963f7d28e17f72; req2 sends "abc" → match_found = 1, match_id = 2, match_msg = req2's message; later non-matching responses leave all three unchanged.
